// File: rtl/multi_alarm_calendar_if.sv
// Control inputs and display outputs of the calendar/alarm core.
// There is no valid/ready handshake on this bus: every input is a level
// sampled on each rising Pulse edge (one edge per second), and every output
// is valid for the whole cycle that follows that edge.
interface multi_alarm_calendar_if #(
  parameter int NA = 4,
  parameter int YW = 7
);
  localparam int AW = (NA > 1) ? $clog2(NA) : 1;

  logic          Timeset;
  logic          Alarmset;
  logic          Minadv;
  logic          Hrsadv;
  logic          Dayadv;
  logic          Datadv;
  logic          Monadv;
  logic          Yradv;
  logic [AW-1:0] Asel;
  logic [NA-1:0] Alarmon;
  logic          Snooze;

  logic [5:0]    TSec;
  logic [5:0]    TMin;
  logic [4:0]    THrs;
  logic [2:0]    TDays;
  logic [4:0]    TDate;
  logic [3:0]    TMonth;
  logic [YW-1:0] TYear;
  logic [5:0]    AMin;
  logic [4:0]    AHrs;
  logic [2:0]    ADays;
  logic [NA-1:0] Ring;
  logic          Buzz;
  // Per-channel FSM state, two bits per channel, for debug and checkers.
  logic [2*NA-1:0] AState;

  modport slave (
    input  Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Datadv, Monadv, Yradv,
           Asel, Alarmon, Snooze,
    output TSec, TMin, THrs, TDays, TDate, TMonth, TYear,
           AMin, AHrs, ADays, Ring, Buzz, AState
  );

  modport master (
    output Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Datadv, Monadv, Yradv,
           Asel, Alarmon, Snooze,
    input  TSec, TMin, THrs, TDays, TDate, TMonth, TYear,
           AMin, AHrs, ADays, Ring, Buzz, AState
  );
endinterface

// File: rtl/multi_alarm_calendar.sv
// Calendar clock (sec..year, true month lengths, leap years) with NA alarm
// channels, each with ring timeout and snooze. One Pulse cycle = one second.
module multi_alarm_calendar #(
  parameter int NA     = 4,
  parameter int ND     = 7,
  parameter int YW     = 7,
  parameter int RING_S = 60,
  parameter int SNZ_S  = 300
) (
  input logic                   Pulse,
  input logic                   Reset,
  multi_alarm_calendar_if.slave bus
);
  localparam int AW   = (NA > 1) ? $clog2(NA) : 1;
  localparam int TMAX = (RING_S > SNZ_S) ? RING_S : SNZ_S;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] RING_LD  = TW'(RING_S - 1);
  localparam logic [TW-1:0] SNZ_LD   = TW'(SNZ_S - 1);
  localparam logic [2:0]    DAY_ALL  = 3'(ND);
  localparam logic [2:0]    DOW_LAST = 3'(ND - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RING = 2'd1, S_SNZ = 2'd2} state_t;

  logic [5:0]    r_sec, r_min;
  logic [4:0]    r_hrs;
  logic [2:0]    r_days;
  logic [4:0]    r_date;
  logic [3:0]    r_month;
  logic [YW-1:0] r_year;
  logic [5:0]    r_amin  [NA];
  logic [4:0]    r_ahrs  [NA];
  logic [2:0]    r_adays [NA];
  state_t        r_state [NA];
  logic [TW-1:0] r_timer [NA];
  logic [NA-1:0] r_ring;

  logic [4:0]      w_len_cur, w_len_new, w_date_step, w_date_set;
  logic [3:0]      w_mon_set;
  logic [YW-1:0]   w_year_set;
  logic [NA-1:0]   w_match;
  logic [2*NA-1:0] w_dbg;

  // Year offset 100 (2100) is not a leap year even though divisible by 4.
  function automatic logic [4:0] month_len(input logic [3:0] m, input logic [YW-1:0] y);
    logic [4:0] len;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
      4'd2:    len = (y[1:0] == 2'b00 && 32'(y) != 32'd100) ? 5'd29 : 5'd28;
      default: len = 5'd31;
    endcase
    return len;
  endfunction

  // Set-mode next values; the date clamp uses the month/year after stepping.
  always_comb begin
    w_mon_set   = bus.Monadv ? ((r_month == 4'd12) ? 4'd1 : r_month + 4'd1) : r_month;
    w_year_set  = bus.Yradv ? r_year + YW'(1) : r_year;
    w_len_cur   = month_len(r_month, r_year);
    w_len_new   = month_len(w_mon_set, w_year_set);
    w_date_step = bus.Datadv ? ((r_date >= w_len_cur) ? 5'd1 : r_date + 5'd1) : r_date;
    w_date_set  = ((bus.Monadv || bus.Yradv) && (w_date_step > w_len_new)) ? w_len_new : w_date_step;
  end

  // Alarm match on the current register values; never while setting time.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < NA; i++) begin
      w_match[i] = (r_sec == 6'd0) && (r_min == r_amin[i]) && (r_hrs == r_ahrs[i]) &&
                   ((r_adays[i] == r_days) || (r_adays[i] == DAY_ALL)) &&
                   bus.Alarmon[i] && !bus.Timeset;
    end
  end

  // Timekeeping: set mode steps fields without carry, otherwise tick the chain.
  always_ff @(posedge Pulse) begin
    if (Reset) begin
      r_sec   <= '0;
      r_min   <= '0;
      r_hrs   <= '0;
      r_days  <= '0;
      r_date  <= 5'd1;
      r_month <= 4'd1;
      r_year  <= '0;
    end else if (bus.Timeset) begin
      if (bus.Minadv) r_min  <= (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
      if (bus.Hrsadv) r_hrs  <= (r_hrs == 5'd23) ? 5'd0 : r_hrs + 5'd1;
      if (bus.Dayadv) r_days <= (r_days >= DOW_LAST) ? 3'd0 : r_days + 3'd1;
      r_date  <= w_date_set;
      r_month <= w_mon_set;
      r_year  <= w_year_set;
    end else begin
      if (r_sec == 6'd59) begin
        r_sec <= '0;
        if (r_min == 6'd59) begin
          r_min <= '0;
          if (r_hrs == 5'd23) begin
            r_hrs  <= '0;
            r_days <= (r_days >= DOW_LAST) ? 3'd0 : r_days + 3'd1;
            if (r_date >= w_len_cur) begin
              r_date <= 5'd1;
              if (r_month == 4'd12) begin
                r_month <= 4'd1;
                r_year  <= r_year + YW'(1);
              end else begin
                r_month <= r_month + 4'd1;
              end
            end else begin
              r_date <= r_date + 5'd1;
            end
          end else begin
            r_hrs <= r_hrs + 5'd1;
          end
        end else begin
          r_min <= r_min + 6'd1;
        end
      end else begin
        r_sec <= r_sec + 6'd1;
      end
    end
  end

  // Alarm settings of the selected channel; Timeset takes priority.
  always_ff @(posedge Pulse) begin
    if (Reset) begin
      for (int i = 0; i < NA; i++) begin
        r_amin[i]  <= '0;
        r_ahrs[i]  <= '0;
        r_adays[i] <= DAY_ALL;
      end
    end else if (bus.Alarmset && !bus.Timeset) begin
      for (int i = 0; i < NA; i++) begin
        if (AW'(i) == bus.Asel) begin
          if (bus.Minadv) r_amin[i]  <= (r_amin[i] == 6'd59) ? 6'd0 : r_amin[i] + 6'd1;
          if (bus.Hrsadv) r_ahrs[i]  <= (r_ahrs[i] == 5'd23) ? 5'd0 : r_ahrs[i] + 5'd1;
          if (bus.Dayadv) r_adays[i] <= (r_adays[i] >= DAY_ALL) ? 3'd0 : r_adays[i] + 3'd1;
        end
      end
    end
  end

  // Per-channel IDLE/RING/SNZ FSM; disarm beats snooze, snooze beats timeout.
  always_ff @(posedge Pulse) begin
    if (Reset) begin
      for (int i = 0; i < NA; i++) begin
        r_state[i] <= S_IDLE;
        r_timer[i] <= '0;
      end
      r_ring <= '0;
    end else begin
      for (int i = 0; i < NA; i++) begin
        case (r_state[i])
          S_IDLE: begin
            if (w_match[i]) begin
              r_state[i] <= S_RING;
              r_timer[i] <= RING_LD;
              r_ring[i]  <= 1'b1;
            end
          end
          S_RING: begin
            if (!bus.Alarmon[i]) begin
              r_state[i] <= S_IDLE;
              r_ring[i]  <= 1'b0;
            end else if (bus.Snooze) begin
              r_state[i] <= S_SNZ;
              r_timer[i] <= SNZ_LD;
              r_ring[i]  <= 1'b0;
            end else if (r_timer[i] == '0) begin
              r_state[i] <= S_IDLE;
              r_ring[i]  <= 1'b0;
            end else begin
              r_timer[i] <= r_timer[i] - TW'(1);
            end
          end
          S_SNZ: begin
            if (!bus.Alarmon[i]) begin
              r_state[i] <= S_IDLE;
            end else if (r_timer[i] == '0) begin
              r_state[i] <= S_RING;
              r_timer[i] <= RING_LD;
              r_ring[i]  <= 1'b1;
            end else begin
              r_timer[i] <= r_timer[i] - TW'(1);
            end
          end
          default: begin
            r_state[i] <= S_IDLE;
            r_ring[i]  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Display mux for the selected alarm channel and packed debug state.
  always_comb begin
    bus.AMin  = r_amin[0];
    bus.AHrs  = r_ahrs[0];
    bus.ADays = r_adays[0];
    w_dbg     = '0;
    for (int i = 0; i < NA; i++) begin
      if (AW'(i) == bus.Asel) begin
        bus.AMin  = r_amin[i];
        bus.AHrs  = r_ahrs[i];
        bus.ADays = r_adays[i];
      end
      w_dbg[2*i +: 2] = r_state[i];
    end
  end

  assign bus.TSec   = r_sec;
  assign bus.TMin   = r_min;
  assign bus.THrs   = r_hrs;
  assign bus.TDays  = r_days;
  assign bus.TDate  = r_date;
  assign bus.TMonth = r_month;
  assign bus.TYear  = r_year;
  assign bus.Ring   = r_ring;
  assign bus.Buzz   = |r_ring;
  assign bus.AState = w_dbg;
endmodule

// File: tb/tb_multi_alarm_calendar.sv
// Bench for multi_alarm_calendar: directed calendar/alarm scenarios plus a
// randomized phase, all compared every cycle against a seconds-of-day model.
module tb_multi_alarm_calendar;
  localparam int NA = 4, ND = 7, YW = 7, RING_S = 60, SNZ_S = 300;
  localparam int AW = 2;
  localparam int B_MIN = 0, B_HRS = 1, B_DAY = 2, B_DAT = 3, B_MON = 4, B_YR = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          ts = 1'b0, as = 1'b0, snooze = 1'b0;
  logic [5:0]    btn = '0;
  logic [AW-1:0] asel = '0;
  logic [NA-1:0] alarmon = '0;

  multi_alarm_calendar_if #(.NA(NA), .YW(YW)) bus ();
  assign bus.Timeset  = ts;
  assign bus.Alarmset = as;
  assign bus.Minadv   = btn[B_MIN];
  assign bus.Hrsadv   = btn[B_HRS];
  assign bus.Dayadv   = btn[B_DAY];
  assign bus.Datadv   = btn[B_DAT];
  assign bus.Monadv   = btn[B_MON];
  assign bus.Yradv    = btn[B_YR];
  assign bus.Asel     = asel;
  assign bus.Alarmon  = alarmon;
  assign bus.Snooze   = snooze;

  multi_alarm_calendar #(.NA(NA), .ND(ND), .YW(YW), .RING_S(RING_S), .SNZ_S(SNZ_S)) dut (
    .Pulse (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  // ---------------- reference model ----------------
  int m_sod, m_dow, m_date, m_mon, m_year;
  int m_amin [NA];
  int m_ahrs [NA];
  int m_aday [NA];
  int m_mode [NA];   // 0 idle, 1 ringing, 2 snoozing
  int m_left [NA];   // seconds left in the current ring/snooze phase
  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  function automatic int mlen(input int m, input int y);
    int t [12];
    t = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 2 && (y % 4) == 0 && y != 100) return 29;
    return t[m-1];
  endfunction

  task automatic model_step();
    bit match [NA];
    int s, mi, h;
    if (rst) begin
      m_sod = 0; m_dow = 0; m_date = 1; m_mon = 1; m_year = 0;
      for (int i = 0; i < NA; i++) begin
        m_amin[i] = 0; m_ahrs[i] = 0; m_aday[i] = ND; m_mode[i] = 0; m_left[i] = 0;
      end
      return;
    end
    for (int i = 0; i < NA; i++)
      match[i] = (m_sod % 60 == 0) && ((m_sod / 60) % 60 == m_amin[i]) &&
                 (m_sod / 3600 == m_ahrs[i]) && (m_aday[i] == ND || m_aday[i] == m_dow) &&
                 alarmon[i] && !ts;
    for (int i = 0; i < NA; i++) begin
      case (m_mode[i])
        0: if (match[i]) begin m_mode[i] = 1; m_left[i] = RING_S; end
        1: begin
          if (!alarmon[i]) m_mode[i] = 0;
          else if (snooze) begin m_mode[i] = 2; m_left[i] = SNZ_S; end
          else begin
            m_left[i]--;
            if (m_left[i] == 0) m_mode[i] = 0;
          end
        end
        default: begin
          if (!alarmon[i]) m_mode[i] = 0;
          else begin
            m_left[i]--;
            if (m_left[i] == 0) begin m_mode[i] = 1; m_left[i] = RING_S; end
          end
        end
      endcase
    end
    if (ts) begin
      s = m_sod % 60; mi = (m_sod / 60) % 60; h = m_sod / 3600;
      if (btn[B_MIN]) mi = (mi + 1) % 60;
      if (btn[B_HRS]) h = (h + 1) % 24;
      m_sod = h * 3600 + mi * 60 + s;
      if (btn[B_DAY]) m_dow = (m_dow + 1) % ND;
      if (btn[B_DAT]) m_date = m_date % mlen(m_mon, m_year) + 1;
      if (btn[B_MON]) m_mon = m_mon % 12 + 1;
      if (btn[B_YR])  m_year = (m_year + 1) % (1 << YW);
      if ((btn[B_MON] || btn[B_YR]) && m_date > mlen(m_mon, m_year)) m_date = mlen(m_mon, m_year);
    end else begin
      if (as) begin
        if (btn[B_MIN]) m_amin[asel] = (m_amin[asel] + 1) % 60;
        if (btn[B_HRS]) m_ahrs[asel] = (m_ahrs[asel] + 1) % 24;
        if (btn[B_DAY]) m_aday[asel] = (m_aday[asel] + 1) % (ND + 1);
      end
      m_sod++;
      if (m_sod == 86400) begin
        m_sod = 0;
        m_dow = (m_dow + 1) % ND;
        m_date++;
        if (m_date > mlen(m_mon, m_year)) begin
          m_date = 1;
          m_mon++;
          if (m_mon > 12) begin m_mon = 1; m_year = (m_year + 1) % (1 << YW); end
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      int exp_ring;
      exp_ring = 0;
      for (int i = 0; i < NA; i++) if (m_mode[i] == 1) exp_ring |= (1 << i);
      chk("tsec",   int'(bus.TSec),   m_sod % 60);
      chk("tmin",   int'(bus.TMin),   (m_sod / 60) % 60);
      chk("thrs",   int'(bus.THrs),   m_sod / 3600);
      chk("tdays",  int'(bus.TDays),  m_dow);
      chk("tdate",  int'(bus.TDate),  m_date);
      chk("tmonth", int'(bus.TMonth), m_mon);
      chk("tyear",  int'(bus.TYear),  m_year);
      chk("amin",   int'(bus.AMin),   m_amin[asel]);
      chk("ahrs",   int'(bus.AHrs),   m_ahrs[asel]);
      chk("adays",  int'(bus.ADays),  m_aday[asel]);
      chk("ring",   int'(bus.Ring),   exp_ring);
      chk("buzz",   int'(bus.Buzz),   (exp_ring != 0) ? 1 : 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int which, input int n);
    for (int k = 0; k < n; k++) begin
      btn[which] = 1'b1;
      tick(1);
    end
    btn[which] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; ts = 1'b0; as = 1'b0; btn = '0; snooze = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  // Sets year/month/date/weekday steps from reset, then 23:59, seconds at 0.
  task automatic set_date(input int yr, input int mon, input int dat, input int day);
    ts = 1'b1;
    press(B_YR, yr);
    press(B_MON, mon);
    press(B_DAT, dat);
    press(B_DAY, day);
    press(B_HRS, 23);
    press(B_MIN, 59);
    ts = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick(2);
    rst = 1'b0;
    check_en = 1'b1;
    chk("rst_tsec", int'(bus.TSec), 0);
    chk("rst_tdate", int'(bus.TDate), 1);
    chk("rst_tmonth", int'(bus.TMonth), 1);
    chk("rst_adays", int'(bus.ADays), 7);
    chk("rst_ring", int'(bus.Ring), 0);

    // Leap year 4: Feb 28 rolls to Feb 29.
    do_reset(); set_date(4, 1, 27, 0);
    tick(59);
    chk("leap4_pre_sec", int'(bus.TSec), 59);
    tick(1);
    chk("leap4_date", int'(bus.TDate), 29);
    chk("leap4_month", int'(bus.TMonth), 2);
    chk("leap4_hrs", int'(bus.THrs), 0);
    chk("leap4_days", int'(bus.TDays), 1);

    // Year 1 and year 100: Feb 28 rolls to Mar 1.
    do_reset(); set_date(1, 1, 27, 0);
    tick(60);
    chk("y1_date", int'(bus.TDate), 1);
    chk("y1_month", int'(bus.TMonth), 3);
    do_reset(); set_date(100, 1, 27, 0);
    tick(60);
    chk("y100_date", int'(bus.TDate), 1);
    chk("y100_month", int'(bus.TMonth), 3);

    // Year rollover from 12-31 23:59:59, year 5, weekday 6.
    do_reset(); set_date(5, 11, 30, 6);
    tick(60);
    chk("yroll_year", int'(bus.TYear), 6);
    chk("yroll_month", int'(bus.TMonth), 1);
    chk("yroll_date", int'(bus.TDate), 1);
    chk("yroll_days", int'(bus.TDays), 0);
    chk("yroll_min", int'(bus.TMin), 0);

    // Date clamp on month step: Jan 31 -> Feb 28 in year 1; seconds held.
    do_reset();
    ts = 1'b1;
    press(B_YR, 1);
    press(B_DAT, 30);
    chk("clamp_pre_date", int'(bus.TDate), 31);
    press(B_MON, 1);
    chk("clamp_month", int'(bus.TMonth), 2);
    chk("clamp_date", int'(bus.TDate), 28);
    chk("clamp_sec", int'(bus.TSec), 0);
    ts = 1'b0;

    // Channel 2 at 07:30 every day: ring, timeout, snooze.
    do_reset();
    asel = 2'd2; as = 1'b1;
    press(B_HRS, 7);
    press(B_MIN, 30);
    as = 1'b0;
    chk("a2_amin", int'(bus.AMin), 30);
    chk("a2_ahrs", int'(bus.AHrs), 7);
    alarmon = 4'b0100;
    ts = 1'b1;
    press(B_HRS, 7);
    press(B_MIN, 29);
    ts = 1'b0;
    tick(23);
    chk("a2_at_min", int'(bus.TMin), 30);
    chk("a2_at_sec", int'(bus.TSec), 0);
    chk("a2_at_ring", int'(bus.Ring), 0);
    tick(1);
    chk("a2_ring_on", int'(bus.Ring), 4);
    chk("a2_buzz_on", int'(bus.Buzz), 1);
    tick(59);
    chk("a2_ring_last", int'(bus.Ring), 4);
    tick(1);
    chk("a2_ring_off", int'(bus.Ring), 0);
    chk("a2_buzz_off", int'(bus.Buzz), 0);
    ts = 1'b1;
    press(B_MIN, 58);
    ts = 1'b0;
    tick(61);
    chk("snz_ring1", int'(bus.Ring), 4);
    tick(9);
    snooze = 1'b1;
    tick(1);
    snooze = 1'b0;
    chk("snz_low_first", int'(bus.Ring), 0);
    tick(299);
    chk("snz_low_last", int'(bus.Ring), 0);
    tick(1);
    chk("snz_back", int'(bus.Ring), 4);
    tick(59);
    chk("snz_back_last", int'(bus.Ring), 4);
    tick(1);
    chk("snz_done", int'(bus.Ring), 0);

    // Disarm while snoozing: stays silent past the snooze period.
    alarmon = 4'b0100;
    do_reset();
    tick(1);
    chk("dis_ring", int'(bus.Ring), 4);
    snooze = 1'b1;
    tick(1);
    snooze = 1'b0;
    alarmon = 4'b0000;
    tick(SNZ_S + 10);
    chk("dis_silent", int'(bus.Ring), 0);

    // Reset with two channels ringing.
    alarmon = 4'b0011;
    do_reset();
    tick(1);
    chk("mr_ring", int'(bus.Ring), 3);
    tick(5);
    rst = 1'b1;
    tick(1);
    chk("mr_ring_rst", int'(bus.Ring), 0);
    chk("mr_buzz_rst", int'(bus.Buzz), 0);
    chk("mr_sec_rst", int'(bus.TSec), 0);
    chk("mr_month_rst", int'(bus.TMonth), 1);
    chk("mr_adays_rst", int'(bus.ADays), 7);
    rst = 1'b0;

    // Randomized phase.
    alarmon = '1;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst    = ($urandom_range(0, 299) == 0);
      ts     = ($urandom_range(0, 19) == 0);
      as     = ($urandom_range(0, 9) == 0);
      btn    = 6'($urandom_range(0, 63));
      asel   = AW'($urandom_range(0, NA - 1));
      snooze = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 49) == 0) alarmon[$urandom_range(0, NA - 1)] ^= 1'b1;
      tick(1);
    end
    rst = 1'b0; ts = 1'b0; as = 1'b0; btn = '0; snooze = 1'b0;
    tick(2);

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
